// File: rtl/adc_osr_param.sv
// adc_osr_param: run-time selectable 2^m oversampling accumulator with left-justified window sum and completion strobe
module adc_osr_param #(
  parameter int DATA_W       = 12,
  parameter int MAX_OSR_LOG2 = 4,
  parameter int MODE_W       = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           clear_in,
  input  logic [MODE_W-1:0]              osr_mode_in,
  input  logic [DATA_W-1:0]              data_in,
  output logic [DATA_W+MAX_OSR_LOG2-1:0] data_out,
  output logic                           conversion_finished_strobe_out,
  output logic                           busy_out
);
  localparam int OW = DATA_W + MAX_OSR_LOG2;
  localparam int CW = MAX_OSR_LOG2 > 0 ? MAX_OSR_LOG2 : 1;
  localparam logic [MODE_W-1:0] MAXM = MODE_W'(MAX_OSR_LOG2);
  logic [OW-1:0] acc_q, acc_d, dout_q, dout_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MODE_W-1:0] mlat_q, mlat_d, m_cur;
  logic [CW:0] lim;
  logic stb_q, stb_d, last;
  always_comb begin
    m_cur  = cnt_q == '0 ? (osr_mode_in > MAXM ? MAXM : osr_mode_in) : mlat_q;
    lim    = ((CW+1)'(1) << m_cur) - (CW+1)'(1);
    last   = {1'b0, cnt_q} == lim;
    sum    = (cnt_q == '0 ? '0 : acc_q) + OW'(data_in);
    mlat_d = m_cur;
    acc_d  = clear_in ? '0 : ena ? (last ? '0 : sum) : acc_q;
    cnt_d  = clear_in ? '0 : ena ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    stb_d  = ena & ~clear_in & last;
    dout_d = stb_d ? sum << (MAXM - m_cur) : dout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mlat_q <= '0;
      dout_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mlat_q <= mlat_d;
      dout_q <= dout_d;
      stb_q  <= stb_d;
    end
  end
  assign data_out = dout_q;
  assign conversion_finished_strobe_out = stb_q;
  assign busy_out = cnt_q != '0;
endmodule

// File: tb/tb_adc_osr_param.sv
// tb_adc_osr_param: table vectors, directed corner sequences and randomized stimulus against a window-level model
module tb_adc_osr_param;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, clear_in = 1'b0;
  logic [2:0] osr_mode_in = '0;
  logic [11:0] data_in = '0;
  logic [15:0] data_out;
  logic conversion_finished_strobe_out, busy_out;
  int nchk = 0, nerr = 0;
  typedef struct {
    logic e, c;
    logic [2:0] m;
    logic [11:0] d;
    logic [15:0] o;
    logic s, b;
  } vec_t;
  vec_t tab[$];
  int win[$];
  int wm = 0;
  logic [15:0] exp_out = '0;
  logic exp_stb = 1'b0;
  adc_osr_param dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear_in(clear_in),
    .osr_mode_in(osr_mode_in), .data_in(data_in), .data_out(data_out),
    .conversion_finished_strobe_out(conversion_finished_strobe_out), .busy_out(busy_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic add(input logic e, c, input logic [2:0] m, input logic [11:0] d, input logic [15:0] o, input logic s, b);
    vec_t v;
    v.e = e; v.c = c; v.m = m; v.d = d; v.o = o; v.s = s; v.b = b;
    tab.push_back(v);
  endtask
  task automatic model_reset();
    win.delete();
    exp_out = '0;
    exp_stb = 1'b0;
  endtask
  task automatic step(input logic e, c, input logic [2:0] m, input logic [11:0] d);
    int sum;
    @(negedge clk);
    ena = e; clear_in = c; osr_mode_in = m; data_in = d;
    @(posedge clk);
    #1;
    exp_stb = 1'b0;
    if (c) win.delete();
    else if (e) begin
      if (win.size() == 0) wm = m > 4 ? 4 : int'(m);
      win.push_back(int'(d));
      if (win.size() == (1 << wm)) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        exp_out = 16'(sum << (4 - wm));
        exp_stb = 1'b1;
        win.delete();
      end
    end
    ena = 1'b0; clear_in = 1'b0;
    chk("model data_out", data_out, exp_out);
    chk("model strobe", conversion_finished_strobe_out, exp_stb);
    chk("model busy", busy_out, win.size() != 0);
  endtask
  initial begin
    add(1, 0, 0, 12'hABC, 16'hABC0, 1, 0);
    add(0, 0, 2, 12'h000, 16'hABC0, 0, 0);
    add(1, 0, 2, 12'h001, 16'hABC0, 0, 1);
    add(0, 0, 2, 12'h000, 16'hABC0, 0, 1);
    add(1, 0, 2, 12'h002, 16'hABC0, 0, 1);
    add(1, 0, 2, 12'h003, 16'hABC0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 2, 12'h000, 16'hABC0, 0, 1);
    add(1, 0, 2, 12'h004, 16'h0028, 1, 0);
    add(0, 0, 2, 12'h000, 16'h0028, 0, 0);
    add(1, 0, 2, 12'h100, 16'h0028, 0, 1);
    add(1, 0, 2, 12'h100, 16'h0028, 0, 1);
    add(1, 1, 2, 12'h100, 16'h0028, 0, 0);
    add(0, 1, 2, 12'h000, 16'h0028, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 2, 12'h001, 16'h0028, 0, 1);
    add(1, 0, 2, 12'h001, 16'h0010, 1, 0);
    add(1, 0, 1, 12'h005, 16'h0010, 0, 1);
    add(1, 0, 3, 12'h006, 16'h0058, 1, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 3, 12'h001, 16'h0058, 0, 1);
    add(1, 0, 3, 12'h001, 16'h0010, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_out", data_out, 0);
    chk("reset strobe", conversion_finished_strobe_out, 0);
    chk("reset busy", busy_out, 0);
    rst_n = 1'b1;
    model_reset();
    foreach (tab[i]) begin
      step(tab[i].e, tab[i].c, tab[i].m, tab[i].d);
      chk($sformatf("vec%0d data_out", i), data_out, tab[i].o);
      chk($sformatf("vec%0d strobe", i), conversion_finished_strobe_out, tab[i].s);
      chk($sformatf("vec%0d busy", i), busy_out, tab[i].b);
    end
    for (int i = 0; i < 16; i++) step(1, 0, 4, 12'hFFF);
    chk("m4 full-scale sum", data_out, 16'hFFF0);
    chk("m4 strobe", conversion_finished_strobe_out, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 7, 12'h001);
    chk("clamp no early strobe", conversion_finished_strobe_out, 0);
    step(1, 0, 7, 12'h001);
    chk("clamp sum", data_out, 16'h0010);
    for (int i = 0; i < 5; i++) step(1, 0, 3, 12'h0F0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset data_out", data_out, 0);
    chk("async reset busy", busy_out, 0);
    chk("async reset strobe", conversion_finished_strobe_out, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0, 3, 12'h002);
    chk("post-reset window", data_out, 16'h0020);
    chk("post-reset strobe", conversion_finished_strobe_out, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), 12'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
